adc_capture_ctrl: RTL and testbench
===================================

ADC_CAPTURE_CTRL -- requirements
Module: adc_capture_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset.
REQ-002 clk_i  input  1  system clock; all state changes on rising edge.
REQ-003 rst_ni  input  1  asynchronous active-low reset.
REQ-004 start_i  input  1  level-sampled request to begin a capture burst; honoured only in IDLE.
REQ-005 abort_i  input  1  request to stop the burst after the read in progress completes.
REQ-006 period_i  input  16  sample pacing interval in clk_i cycles, measured from one strr_o pulse to the next; sampled on burst start.
REQ-007 eor_i  input  1  one-cycle end-of-read pulse from the SPI read engine.
REQ-008 rdata_i  input  12  ADC sample from the SPI read engine; valid in the cycle eor_i is high.
REQ-009 strr_o  output  1  one-cycle start-of-read pulse to the SPI read engine.
REQ-010 we_o  output  1  one-cycle sample-memory write enable.
REQ-011 addr_o  output  10  sample-memory write address (= sample index).
REQ-012 wdata_o  output  12  sample-memory write data.
REQ-013 busy_o  output  1  high in every state except IDLE.
REQ-014 end_o  output  1  high in IDLE; low otherwise.
REQ-015 ovr_o  output  1  sticky flag: a pacing period expired before the previous read finished.

Function
REQ-016 States SHALL be IDLE, START, WAIT, STORE, PACE.
REQ-017 IDLE: end_o=1; on start_i=1, latch period_i, clear sample index to 0, clear ovr_o, load pace timer, go START.
REQ-018 START: strr_o=1 for exactly one cycle; go WAIT.
REQ-019 WAIT: hold until eor_i=1; in that cycle register rdata_i into wdata_o; go STORE.
REQ-020 STORE: we_o=1 with addr_o=current index and wdata_o=captured sample; if index==1023 or abort latched, go IDLE; else increment index, go PACE.
REQ-021 PACE: hold until pace timer expires, then go START.
REQ-022 Pace timer SHALL count period_i cycles starting in the START cycle; a latched period of 0 to 4 SHALL be treated as back-to-back (PACE exits after one cycle).
REQ-023 If the pace timer expires while in WAIT or STORE, ovr_o SHALL set and remain set until the next burst start; the sequence SHALL continue without skipping an index.
REQ-024 abort_i asserted in any non-IDLE state SHALL be latched; the burst SHALL end after the next STORE, so the sample of a started read is always written.
REQ-025 abort_i in IDLE SHALL be ignored; start_i and abort_i high together in IDLE SHALL start a burst that stops after index 0.
REQ-026 start_i outside IDLE SHALL be ignored; changes to period_i during a burst SHALL have no effect.
REQ-027 eor_i outside WAIT SHALL be ignored.
REQ-028 The index SHALL be 10 bits; no wrap inside a burst (1024 writes, addresses 0..1023, ascending).
REQ-029 Outputs strr_o, we_o, end_o, busy_o SHALL be decoded from registered state only (no combinational path from inputs).

Reset
REQ-030 On rst_ni=0, asynchronously: state=IDLE, strr_o=0, we_o=0, addr_o=0, wdata_o=0, busy_o=0, end_o=1, ovr_o=0, abort latch=0, pace timer=0.
REQ-031 Reset mid-burst SHALL abandon the burst with no further strr_o or we_o pulses; an eor_i after release SHALL be ignored.

Structure
REQ-032 Shared package adc_pkg SHALL hold state encodings, N_SAMPLES=1024, SAMPLE_W=12, ADDR_W=10, PERIOD_W=16.
REQ-033 The pace timer SHALL be a separate sub-module pace_timer (load, expire pulse, 16-bit down-counter).

Verification
REQ-034 period_i=100, start pulse, engine returns eor_i 20 cycles after each strr_o with rdata=index -> 1024 we_o pulses, addr 0..1023, wdata==addr, strr_o spacing exactly 100 cycles, ovr_o=0, end_o=1 after.
REQ-035 period_i=10, eor_i 20 cycles after strr_o -> ovr_o=1 after first sample, all 1024 samples still written in order.
REQ-036 abort_i pulse in WAIT of index 5 -> we_o at addr 5, no further strr_o, IDLE next cycle.
REQ-037 rst_ni low during WAIT of index 300 -> outputs at reset values immediately; delayed eor_i produces no we_o.
REQ-038 period_i=0 -> strr_o every 4 cycles (START, WAIT with immediate eor_i, STORE, PACE); start_i during burst ignored.

Source files
------------

// File: rtl/adc_pkg.sv
// adc_pkg: shared constants, FSM state encodings and helpers for the ADC capture
// controller and its pace timer.
//   N_SAMPLES  - samples per burst (one full sample memory)
//   SAMPLE_W   - ADC sample width
//   ADDR_W     - sample-memory address / sample index width
//   PERIOD_W   - pacing period width
package adc_pkg;

    localparam int unsigned N_SAMPLES  = 1024;
    localparam int unsigned SAMPLE_W   = 12;
    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned PERIOD_W   = 16;

    // Shortest possible START->START loop (START, WAIT, STORE, PACE).
    localparam int unsigned MIN_PERIOD = 4;

    typedef logic [2:0] state_t;

    localparam state_t StIdle  = 3'd0;
    localparam state_t StStart = 3'd1;
    localparam state_t StWait  = 3'd2;
    localparam state_t StStore = 3'd3;
    localparam state_t StPace  = 3'd4;

    // Periods shorter than the minimum loop collapse to back-to-back operation.
    function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] p);
        return (p < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : p;
    endfunction

endpackage

// File: rtl/pace_timer.sv
// pace_timer: down-counter that paces successive reads.
//   clk_i      - clock
//   rst_ni     - asynchronous active-low reset (count cleared)
//   load_i     - load load_val_i into the counter this cycle
//   load_val_i - value to load
//   expire_o   - one-cycle pulse in the last cycle of the period (count == 1)
//   done_o     - level: period has elapsed (count <= 1); stays high until reloaded
module pace_timer
    import adc_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                load_i,
    input  logic [PERIOD_W-1:0] load_val_i,
    output logic                expire_o,
    output logic                done_o
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - PERIOD_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == PERIOD_W'(1));
    assign done_o   = (cnt_q <= PERIOD_W'(1));

endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: paces an SPI ADC read engine through a burst of up to
// N_SAMPLES reads and writes each sample into a sample memory.
//   clk_i    - clock                      rst_ni  - async active-low reset
//   start_i  - begin a burst (IDLE only)  abort_i - stop after the read in flight
//   period_i - strr_o to strr_o interval, sampled at burst start
//   eor_i    - end-of-read pulse          rdata_i - sample, valid with eor_i
//   strr_o   - start-of-read pulse        we_o    - sample-memory write enable
//   addr_o   - write address (index)      wdata_o - write data
//   busy_o   - not IDLE                   end_o   - IDLE
//   ovr_o    - sticky: a period elapsed before the previous read finished
module adc_capture_ctrl
    import adc_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic                eor_i,
    input  logic [SAMPLE_W-1:0] rdata_i,
    output logic                strr_o,
    output logic                we_o,
    output logic [ADDR_W-1:0]   addr_o,
    output logic [SAMPLE_W-1:0] wdata_o,
    output logic                busy_o,
    output logic                end_o,
    output logic                ovr_o
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [SAMPLE_W-1:0] wdata_q, wdata_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                abort_q, abort_d;
    logic                ovr_q, ovr_d;

    logic timer_load, timer_expire, timer_done;

    // Reloading in START makes the period run from one strr_o to the next;
    // loading period-1 lands done_o on the cycle before the next START.
    assign timer_load = (state_q == StStart);

    pace_timer u_pace_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (timer_load),
        .load_val_i (period_q - PERIOD_W'(1)),
        .expire_o   (timer_expire),
        .done_o     (timer_done)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        period_d = period_q;
        abort_d  = abort_q;
        ovr_d    = ovr_q;

        if ((state_q != StIdle) && abort_i) begin
            abort_d = 1'b1;
        end

        if (timer_expire && ((state_q == StWait) || (state_q == StStore))) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    period_d = clamp_period(period_i);
                    idx_d    = '0;
                    ovr_d    = 1'b0;
                    // start+abort together captures exactly one sample
                    abort_d  = abort_i;
                    state_d  = StStart;
                end
            end
            StStart: begin
                state_d = StWait;
            end
            StWait: begin
                if (eor_i) begin
                    wdata_d = rdata_i;
                    state_d = StStore;
                end
            end
            StStore: begin
                if ((idx_q == ADDR_W'(N_SAMPLES - 1)) || abort_q || abort_i) begin
                    abort_d = 1'b0;
                    state_d = StIdle;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = StPace;
                end
            end
            StPace: begin
                // done_o is a level, so an overrun period exits PACE immediately
                if (timer_done) begin
                    state_d = StStart;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            wdata_q  <= '0;
            period_q <= '0;
            abort_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            period_q <= period_d;
            abort_q  <= abort_d;
            ovr_q    <= ovr_d;
        end
    end

    assign strr_o  = (state_q == StStart);
    assign we_o    = (state_q == StStore);
    assign busy_o  = (state_q != StIdle);
    assign end_o   = (state_q == StIdle);
    assign addr_o  = idx_q;
    assign wdata_o = wdata_q;
    assign ovr_o   = ovr_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl: table of bursts plus a reset-mid-burst sequence.
module tb_adc_capture_ctrl;
    import adc_pkg::*;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic                start_i, abort_i, eor_i;
    logic [PERIOD_W-1:0] period_i;
    logic [SAMPLE_W-1:0] rdata_i;
    logic                strr_o, we_o, busy_o, end_o, ovr_o;
    logic [ADDR_W-1:0]   addr_o;
    logic [SAMPLE_W-1:0] wdata_o;

    adc_capture_ctrl dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (start_i),
        .abort_i  (abort_i),
        .period_i (period_i),
        .eor_i    (eor_i),
        .rdata_i  (rdata_i),
        .strr_o   (strr_o),
        .we_o     (we_o),
        .addr_o   (addr_o),
        .wdata_o  (wdata_o),
        .busy_o   (busy_o),
        .end_o    (end_o),
        .ovr_o    (ovr_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // delay: cycles from the strr_o cycle to the eor_i cycle (1 = eor in first WAIT cycle)
    typedef struct packed {
        int period;
        int delay;
        int abort_idx;   // index whose WAIT sees an abort pulse, -1 for none
        bit start_abort; // start_i and abort_i together
        bit start_mid;   // pulse start_i mid-burst
        int exp_writes;
        int exp_spacing;
        bit exp_ovr;
    } vec_t;

    vec_t vecs[8];

    task automatic run_burst(input vec_t v, input int vi);
        int cyc = 0, strr_cnt = 0, we_cnt = 0, last_strr = -1;
        int spacing_err = 0, order_err = 0, eor_at = -1, abort_at = -1;
        int last_we = -1, end_cyc = -1, early_ovr = -1, budget;
        budget = 1100 * v.exp_spacing + 200;
        period_i = PERIOD_W'(v.period);
        start_i  = 1'b1;
        abort_i  = v.start_abort;
        @(posedge clk_i); #1;
        start_i  = 1'b0;
        // a changed period mid-burst must not matter
        period_i = PERIOD_W'(v.period) ^ 16'h00ff;
        while (cyc < budget) begin
            cyc++;
            eor_i   = 1'b0;
            abort_i = 1'b0;
            start_i = 1'b0;
            if (strr_o) begin
                if (last_strr >= 0 && (cyc - last_strr) != v.exp_spacing) spacing_err++;
                last_strr = cyc;
                eor_at    = cyc + v.delay;
                if (strr_cnt == v.abort_idx) abort_at = cyc + 1;
                strr_cnt++;
            end
            if (cyc == abort_at) abort_i = 1'b1;
            if (cyc == eor_at) begin
                eor_i   = 1'b1;
                rdata_i = SAMPLE_W'(strr_cnt - 1);
            end
            if (we_o) begin
                if (int'(addr_o) != we_cnt || int'(wdata_o) != we_cnt) order_err++;
                if (we_cnt == 1) early_ovr = int'(ovr_o);
                we_cnt++;
                last_we = cyc;
            end
            if (v.start_mid && cyc == 40) start_i = 1'b1;
            if (end_o) begin
                end_cyc = cyc;
                break;
            end
            @(posedge clk_i); #1;
        end
        eor_i = 1'b0; abort_i = 1'b0; start_i = 1'b0;
        check($sformatf("v%0d burst_ended", vi), int'(end_cyc >= 0), 1);
        check($sformatf("v%0d write_count", vi), we_cnt, v.exp_writes);
        check($sformatf("v%0d strr_count", vi), strr_cnt, v.exp_writes);
        check($sformatf("v%0d addr_data_order_errors", vi), order_err, 0);
        check($sformatf("v%0d strr_spacing_errors", vi), spacing_err, 0);
        check($sformatf("v%0d idle_after_last_store", vi), end_cyc, last_we + 1);
        check($sformatf("v%0d ovr_final", vi), int'(ovr_o), int'(v.exp_ovr));
        check($sformatf("v%0d busy_final", vi), int'(busy_o), 0);
        if (v.exp_writes > 1)
            check($sformatf("v%0d ovr_after_first_sample", vi), early_ovr, int'(v.exp_ovr));
        @(posedge clk_i); #1;
    endtask

    initial begin
        int we_seen, strr_seen, cyc, strr_cnt, eor_at, widx;
        //            period dly abort sa sm writes spacing ovr
        vecs[0] = '{100, 20,  5, 1'b0, 1'b0,    6, 100, 1'b0};
        vecs[1] = '{ 25, 20, -1, 1'b0, 1'b0, 1024,  25, 1'b0};
        vecs[2] = '{ 10, 12, -1, 1'b0, 1'b0, 1024,  15, 1'b1};
        vecs[3] = '{  0,  1, -1, 1'b0, 1'b1, 1024,   4, 1'b0};
        vecs[4] = '{  3,  1, -1, 1'b0, 1'b0, 1024,   4, 1'b0};
        vecs[5] = '{  5,  1, -1, 1'b0, 1'b0, 1024,   5, 1'b0};
        vecs[6] = '{  4,  2, -1, 1'b0, 1'b0, 1024,   5, 1'b1};
        vecs[7] = '{ 50,  5, -1, 1'b1, 1'b0,    1,  50, 1'b0};

        rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0; eor_i = 1'b0;
        period_i = '0; rdata_i = '0;
        #22;
        check("reset strr", int'(strr_o), 0);
        check("reset we", int'(we_o), 0);
        check("reset addr", int'(addr_o), 0);
        check("reset wdata", int'(wdata_o), 0);
        check("reset busy", int'(busy_o), 0);
        check("reset end", int'(end_o), 1);
        check("reset ovr", int'(ovr_o), 0);
        @(negedge clk_i); rst_ni = 1'b1;
        // abort alone in IDLE and eor in IDLE do nothing
        abort_i = 1'b1; eor_i = 1'b1;
        @(posedge clk_i); #1;
        abort_i = 1'b0; eor_i = 1'b0;
        @(posedge clk_i); #1;
        check("idle abort/eor ignored busy", int'(busy_o), 0);
        check("idle abort/eor ignored we", int'(we_o), 0);

        for (int i = 0; i < 8; i++) run_burst(vecs[i], i);

        // Reset during WAIT of index 300, then a late eor_i.
        period_i = 16'd4; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        strr_cnt = 0; eor_at = -1; widx = -1;
        for (cyc = 1; cyc < 3000; cyc++) begin
            eor_i = 1'b0;
            if (strr_o) begin
                strr_cnt++;
                if (strr_cnt == 301) break;
                eor_at = cyc + 1;
            end
            if (cyc == eor_at) begin
                eor_i = 1'b1; rdata_i = SAMPLE_W'(strr_cnt - 1);
            end
            if (we_o) widx = int'(addr_o);
            @(posedge clk_i); #1;
        end
        eor_i = 1'b0;
        check("rst seq reached index 300", strr_cnt, 301);
        check("rst seq last write addr", widx, 299);
        @(posedge clk_i); #2;  // now in WAIT of index 300
        check("rst seq in wait busy", int'(busy_o), 1);
        rst_ni = 1'b0;
        #1;
        check("midrst strr", int'(strr_o), 0);
        check("midrst we", int'(we_o), 0);
        check("midrst addr", int'(addr_o), 0);
        check("midrst wdata", int'(wdata_o), 0);
        check("midrst busy", int'(busy_o), 0);
        check("midrst end", int'(end_o), 1);
        @(negedge clk_i); rst_ni = 1'b1;
        @(posedge clk_i); #1;
        eor_i = 1'b1; rdata_i = 12'habc;
        we_seen = 0; strr_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk_i); #1;
            eor_i = 1'b0;
            if (we_o) we_seen++;
            if (strr_o) strr_seen++;
        end
        check("post-reset eor no we", we_seen, 0);
        check("post-reset no strr", strr_seen, 0);
        check("post-reset end", int'(end_o), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
